// File: rtl/alu_result_stage_if.sv
// EX->MEM result-stage bus: EX-side instruction slot, pipeline control and
// the registered MEM-side outputs, flags and saturation counter.
interface alu_result_stage_if;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned REG_W  = 4;
   localparam int unsigned OP_W   = 4;
   localparam int unsigned CNT_W  = 8;

   logic              in_valid;
   logic [OP_W-1:0]   opcode;
   logic [DATA_W-1:0] alu_result;
   logic              alu_ovf;
   logic              sat_err;
   logic [REG_W-1:0]  wr_reg;
   logic              wr_en;
   logic              stall;
   logic              flush;

   logic              out_valid;
   logic [DATA_W-1:0] out_result;
   logic [REG_W-1:0]  out_wr_reg;
   logic              out_wr_en;
   logic              flag_z;
   logic              flag_v;
   logic              flag_n;
   logic [CNT_W-1:0]  sat_count;

   // EX-stage side: drives the slot and controls, observes the stage outputs.
   modport master (
      output in_valid, opcode, alu_result, alu_ovf, sat_err, wr_reg, wr_en, stall, flush,
      input  out_valid, out_result, out_wr_reg, out_wr_en, flag_z, flag_v, flag_n, sat_count
   );

   // Result stage side.
   modport slave (
      input  in_valid, opcode, alu_result, alu_ovf, sat_err, wr_reg, wr_en, stall, flush,
      output out_valid, out_result, out_wr_reg, out_wr_en, flag_z, flag_v, flag_n, sat_count
   );
endinterface

// File: rtl/alu_result_stage.sv
// EX->MEM result pipeline register with Z/V/N flag update and an optional
// PADDSB saturation-event counter enabled by macro SAT_COUNT_EN.
module alu_result_stage (
   input logic                clk,
   input logic                rst_n,
   alu_result_stage_if.slave  bus
);
   localparam int unsigned DATA_W = 16;
   localparam int unsigned REG_W  = 4;
   localparam int unsigned CNT_W  = 8;

   typedef enum logic [3:0] {
      OP_ADD    = 4'd0,
      OP_SUB    = 4'd1,
      OP_XOR    = 4'd2,
      OP_RED    = 4'd3,
      OP_SLL    = 4'd4,
      OP_SRA    = 4'd5,
      OP_ROR    = 4'd6,
      OP_PADDSB = 4'd7
   } opcode_e;

   logic              out_valid_q,  out_valid_d;
   logic [DATA_W-1:0] out_result_q, out_result_d;
   logic [REG_W-1:0]  out_wr_reg_q, out_wr_reg_d;
   logic              out_wr_en_q,  out_wr_en_d;
   logic              flag_z_q,     flag_z_d;
   logic              flag_v_q,     flag_v_d;
   logic              flag_n_q,     flag_n_d;

   logic capture;
   logic result_zero;

   assign capture     = !bus.flush && !bus.stall;
   assign result_zero = (bus.alu_result == DATA_W'(0));

   // Next-state: hold by default, flush kills the slot, capture loads it.
   always_comb begin
      out_valid_d  = out_valid_q;
      out_result_d = out_result_q;
      out_wr_reg_d = out_wr_reg_q;
      out_wr_en_d  = out_wr_en_q;
      flag_z_d     = flag_z_q;
      flag_v_d     = flag_v_q;
      flag_n_d     = flag_n_q;

      if (bus.flush) begin
         out_valid_d = 1'b0;
         out_wr_en_d = 1'b0;
      end else if (capture) begin
         out_valid_d  = bus.in_valid;
         out_result_d = bus.alu_result;
         out_wr_reg_d = bus.wr_reg;
         out_wr_en_d  = bus.wr_en & bus.in_valid;
         if (bus.in_valid) begin
            case (bus.opcode)
               OP_ADD, OP_SUB: begin
                  flag_z_d = result_zero;
                  flag_n_d = bus.alu_result[DATA_W-1];
                  flag_v_d = bus.alu_ovf;
               end
               OP_XOR, OP_SLL, OP_SRA, OP_ROR: begin
                  flag_z_d = result_zero;
               end
               default: ;
            endcase
         end
      end
   end

   // Stage register; reset overrides stall and flush.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         out_result_q <= '0;
         out_wr_reg_q <= '0;
         out_wr_en_q  <= 1'b0;
         flag_z_q     <= 1'b0;
         flag_v_q     <= 1'b0;
         flag_n_q     <= 1'b0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_result_q <= out_result_d;
         out_wr_reg_q <= out_wr_reg_d;
         out_wr_en_q  <= out_wr_en_d;
         flag_z_q     <= flag_z_d;
         flag_v_q     <= flag_v_d;
         flag_n_q     <= flag_n_d;
      end
   end

`ifdef SAT_COUNT_EN
   logic [CNT_W-1:0] sat_count_q, sat_count_d;
   logic             sat_event;

   assign sat_event = capture && bus.in_valid && bus.sat_err &&
                      (bus.opcode == OP_PADDSB);

   // Saturating event counter: sticks at all-ones instead of wrapping.
   always_comb begin
      sat_count_d = sat_count_q;
      if (sat_event && (sat_count_q != {CNT_W{1'b1}})) begin
         sat_count_d = sat_count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sat_count_q <= '0;
      end else begin
         sat_count_q <= sat_count_d;
      end
   end

   assign bus.sat_count = sat_count_q;
`else
   logic unused_sat_err;

   assign unused_sat_err = bus.sat_err;
   assign bus.sat_count  = CNT_W'(0);
`endif

   assign bus.out_valid  = out_valid_q;
   assign bus.out_result = out_result_q;
   assign bus.out_wr_reg = out_wr_reg_q;
   assign bus.out_wr_en  = out_wr_en_q;
   assign bus.flag_z     = flag_z_q;
   assign bus.flag_v     = flag_v_q;
   assign bus.flag_n     = flag_n_q;

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 SHALL have parameter none; all widths fixed (16-bit datapath, 4-bit register index, 4-bit opcode).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 in_valid  input  1  EX-stage slot holds a real instruction.
REQ-005 opcode  input  4  EX-stage opcode: 0 ADD, 1 SUB, 2 XOR, 3 RED, 4 SLL, 5 SRA, 6 ROR, 7 PADDSB, 8-15 non-ALU.
REQ-006 alu_result  input  16  ALU or PADDSB result.
REQ-007 alu_ovf  input  1  signed overflow from ADD/SUB.
REQ-008 sat_err  input  1  PADDSB Error (any nibble saturated).
REQ-009 wr_reg  input  4  destination register index.
REQ-010 wr_en  input  1  destination write enable.
REQ-011 stall  input  1  hold stage contents.
REQ-012 flush  input  1  kill stage contents.
REQ-013 out_valid  output  1  MEM-stage slot valid.
REQ-014 out_result  output  16  registered result.
REQ-015 out_wr_reg  output  4  registered destination index.
REQ-016 out_wr_en  output  1  registered write enable, forced 0 when out_valid=0.
REQ-017 flag_z, flag_v, flag_n  output  1 each  architectural flags.
REQ-018 sat_count  output  8  saturation event counter.

Function
REQ-019 Latency SHALL be exactly one cycle from capture to outputs.
REQ-020 Capture condition: rst_n=1, flush=0, stall=0; on capture out_valid<=in_valid, out_result<=alu_result, out_wr_reg<=wr_reg, out_wr_en<=wr_en&in_valid.
REQ-021 stall=1, flush=0: all outputs and flags SHALL hold their values.
REQ-022 flush=1 SHALL take priority over stall: out_valid<=0, out_wr_en<=0; out_result/out_wr_reg hold; flags and sat_count unchanged.
REQ-023 Flag update only on capture with in_valid=1: ADD/SUB update Z, N, V; XOR/SLL/SRA/ROR update Z only; RED, PADDSB, 8-15 leave all flags unchanged.
REQ-024 Z SHALL be 1 iff alu_result==16'h0000; N SHALL equal alu_result[15]; V SHALL equal alu_ovf.
REQ-025 Flags SHALL be visible the cycle after capture; not updated by invalid slots, stalled or flushed cycles.
REQ-026 sat_count SHALL increment by 1 on capture with in_valid=1, opcode=7, sat_err=1.
REQ-027 sat_count SHALL saturate at 8'hFF (no wrap).
REQ-028 sat_err and alu_ovf SHALL be ignored for opcodes where not specified above.

Reset
REQ-029 On rising clk with rst_n=0: out_valid=0, out_result=0, out_wr_reg=0, out_wr_en=0, flag_z=0, flag_v=0, flag_n=0, sat_count=0.
REQ-030 Reset SHALL override flush and stall; reset mid-stall discards held contents.
REQ-031 First capture SHALL occur on the first rising edge with rst_n=1.

Configuration
REQ-032 Macro SAT_COUNT_EN: defined -> sat_count behaves per REQ-026/027.
REQ-033 SAT_COUNT_EN undefined -> counter register SHALL not be synthesised; sat_count tied to 8'h00; all other behaviour identical.

Verification
REQ-034 Reset then ADD, alu_result=16'h0000, alu_ovf=1 -> next cycle out_valid=1, Z=1, N=0, V=1.
REQ-035 XOR result 16'h8001 after REQ-034 state -> Z=0, N=0 and V=1 retained (XOR updates Z only).
REQ-036 PADDSB sat_err=1 captured 257 times with SAT_COUNT_EN -> sat_count=8'hFF; without macro -> 8'h00 throughout.
REQ-037 SUB result 16'h0000 with stall=1 for 3 cycles then stall=0 -> outputs and Z unchanged during stall, Z=1 one cycle after release.
REQ-038 flush=1 and stall=1 same cycle with valid ADD, wr_en=1 -> out_valid=0, out_wr_en=0, flags unchanged.
REQ-039 rst_n=0 asserted during stall with out_valid=1 -> all outputs zero after that edge.
